// File: rtl/branch_predict_resolve.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predict_resolve
//  Description : EX-stage branch resolution with a built-in branch history
//                table of 2-bit saturating counters. Resolves B-type, jal,
//                jalr and auipc, issues a registered redirect to IF on a
//                misprediction, trains the table and serves the IF lookup.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_predict_resolve #(
    parameter int         XLEN        = 32,
    parameter int         BHT_ENTRIES = 16,
    parameter logic [1:0] CNT_INIT    = 2'b01
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic [3:0]      branch_ctrl,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] data1,
    input  logic [XLEN-1:0] data2,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] if_pc,
    output logic            if_pred_taken,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic [3:0]      branch_type,
    output logic [31:0]     mispredict_cnt
);

    localparam int              IDX       = $clog2(BHT_ENTRIES);
    localparam logic [XLEN-1:0] c_PC_STEP = XLEN'(4);

    logic            r_redirect_valid_q;
    logic            w_redirect_valid_d;
    logic [XLEN-1:0] r_redirect_pc_q;
    logic [XLEN-1:0] w_redirect_pc_d;
    logic [3:0]      r_branch_type_q;
    logic [3:0]      w_branch_type_d;
    logic [31:0]     r_mispredict_cnt_q;
    logic [31:0]     w_mispredict_cnt_d;
    logic [1:0]      r_bht_q [BHT_ENTRIES];
    logic [1:0]      w_bht_d [BHT_ENTRIES];

    logic            w_btype;
    logic            w_jalr;
    logic            w_jal;
    logic            w_auipc;
    logic            w_zero;
    logic            w_slt;
    logic            w_sltu;
    logic            w_cond;
    logic            w_actual_taken;
    logic            w_eff_valid;
    logic            w_redirect;
    logic [IDX-1:0]  w_ex_idx;
    logic [IDX-1:0]  w_if_idx;
    logic            w_unused_if_bits;

    assign w_btype  = branch_ctrl[0];
    assign w_jalr   = branch_ctrl[1];
    assign w_jal    = branch_ctrl[2];
    assign w_auipc  = branch_ctrl[3];

    assign w_zero   = (data1 == data2);
    assign w_slt    = ($signed(data1) < $signed(data2));
    assign w_sltu   = (data1 < data2);

    assign w_ex_idx = ex_pc[IDX+1:2];
    assign w_if_idx = if_pc[IDX+1:2];

    // Only the word-index bits of the fetch PC address the table.
    assign w_unused_if_bits = ^{if_pc[XLEN-1:IDX+2], if_pc[1:0]};

    // B-type condition decode; reserved encodings resolve as not-taken.
    always_comb begin
        w_cond = 1'b0;
        case (func3)
            3'b000:  w_cond = w_zero;
            3'b001:  w_cond = ~w_zero;
            3'b100:  w_cond = w_slt;
            3'b101:  w_cond = ~w_slt;
            3'b110:  w_cond = w_sltu;
            3'b111:  w_cond = ~w_sltu;
            default: w_cond = 1'b0;
        endcase
    end

    // The instruction right behind a redirect is wrong-path and is ignored.
    assign w_eff_valid    = ex_valid & ~r_redirect_valid_q;
    assign w_actual_taken = (w_btype & w_cond) | w_jal | w_jalr;
    assign w_redirect     = w_eff_valid &
                            ((w_btype & (w_cond != ex_pred_taken)) |
                             (w_jal & ~ex_pred_taken) |
                             w_jalr);

    // Next-state for the redirect, type and statistics registers.
    always_comb begin
        w_redirect_valid_d = w_redirect;
        w_redirect_pc_d    = r_redirect_pc_q;
        if (w_redirect) begin
            w_redirect_pc_d = w_actual_taken ? ex_target : (ex_pc + c_PC_STEP);
        end
        w_branch_type_d    = w_eff_valid ? {w_auipc, w_jal, w_jalr, w_btype & w_cond} : 4'b0000;
        w_mispredict_cnt_d = r_mispredict_cnt_q;
        if (w_redirect && (r_mispredict_cnt_q != 32'hFFFF_FFFF)) begin
            w_mispredict_cnt_d = r_mispredict_cnt_q + 32'd1;
        end
    end

    // Train the addressed counter on every resolved B-type, saturating at both ends.
    always_comb begin
        for (int i = 0; i < BHT_ENTRIES; i++) begin
            w_bht_d[i] = r_bht_q[i];
        end
        if (w_eff_valid && w_btype) begin
            if (w_cond) begin
                if (r_bht_q[w_ex_idx] != 2'b11) begin
                    w_bht_d[w_ex_idx] = r_bht_q[w_ex_idx] + 2'b01;
                end
            end else begin
                if (r_bht_q[w_ex_idx] != 2'b00) begin
                    w_bht_d[w_ex_idx] = r_bht_q[w_ex_idx] - 2'b01;
                end
            end
        end
    end

    // State registers; reset takes effect immediately and discards any pending redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_redirect_valid_q <= 1'b0;
            r_redirect_pc_q    <= '0;
            r_branch_type_q    <= 4'b0000;
            r_mispredict_cnt_q <= 32'd0;
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                r_bht_q[i] <= CNT_INIT;
            end
        end else begin
            r_redirect_valid_q <= w_redirect_valid_d;
            r_redirect_pc_q    <= w_redirect_pc_d;
            r_branch_type_q    <= w_branch_type_d;
            r_mispredict_cnt_q <= w_mispredict_cnt_d;
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                r_bht_q[i] <= w_bht_d[i];
            end
        end
    end

    // Lookup reads the stored counter; a same-cycle update is not forwarded.
    assign if_pred_taken  = r_bht_q[w_if_idx][1];
    assign redirect_valid = r_redirect_valid_q;
    assign redirect_pc    = r_redirect_pc_q;
    assign branch_type    = r_branch_type_q;
    assign mispredict_cnt = r_mispredict_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_resolve.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_predict_resolve
//  Description : Directed scoreboard bench for branch_predict_resolve.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predict_resolve;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic [3:0]  branch_ctrl;
    logic [2:0]  func3;
    logic [31:0] data1;
    logic [31:0] data2;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [3:0]  branch_type;
    logic [31:0] mispredict_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic        rv;
        logic [31:0] pc;
        logic [3:0]  bt;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    localparam logic [3:0] c_BR  = 4'b0001;
    localparam logic [3:0] c_JR  = 4'b0010;
    localparam logic [3:0] c_JAL = 4'b0100;
    localparam logic [3:0] c_AUI = 4'b1000;

    branch_predict_resolve #(
        .XLEN        (32),
        .BHT_ENTRIES (16),
        .CNT_INIT    (2'b01)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .ex_valid       (ex_valid),
        .branch_ctrl    (branch_ctrl),
        .func3          (func3),
        .data1          (data1),
        .data2          (data2),
        .ex_pc          (ex_pc),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .if_pc          (if_pc),
        .if_pred_taken  (if_pred_taken),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .branch_type    (branch_type),
        .mispredict_cnt (mispredict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // Drive one EX cycle at the falling edge and queue the response due one cycle later.
    task automatic issue(input string nm, input logic v, input logic [3:0] bc, input logic [2:0] f3,
                         input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] pc,
                         input logic [31:0] tgt, input logic pred,
                         input logic e_rv, input logic [31:0] e_pc, input logic [3:0] e_bt,
                         input logic [31:0] e_cnt);
        exp_t e;
        @(negedge clk);
        ex_valid      = v;
        branch_ctrl   = bc;
        func3         = f3;
        data1         = d1;
        data2         = d2;
        ex_pc         = pc;
        ex_target     = tgt;
        ex_pred_taken = pred;
        e.name = nm;
        e.rv   = e_rv;
        e.pc   = e_pc;
        e.bt   = e_bt;
        e.cnt  = e_cnt;
        exp_q.push_back(e);
    endtask

    task automatic idle(input logic [31:0] e_cnt);
        issue("idle", 1'b0, 4'b0000, 3'b000, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0,
              1'b0, 32'd0, 4'b0000, e_cnt);
    endtask

    // Monitor: compares each registered response against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({e.name, ".redirect_valid"}, {31'd0, redirect_valid}, {31'd0, e.rv});
                chk({e.name, ".branch_type"}, {28'd0, branch_type}, {28'd0, e.bt});
                chk({e.name, ".mispredict_cnt"}, mispredict_cnt, e.cnt);
                if (e.rv) begin
                    chk({e.name, ".redirect_pc"}, redirect_pc, e.pc);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        ex_valid = 1'b0; branch_ctrl = 4'b0; func3 = 3'b0; data1 = '0; data2 = '0;
        ex_pc = '0; ex_target = '0; ex_pred_taken = 1'b0; if_pc = '0;
        repeat (2) @(negedge clk);
        chk("reset.redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("reset.redirect_pc", redirect_pc, 32'd0);
        chk("reset.branch_type", {28'd0, branch_type}, 32'd0);
        chk("reset.mispredict_cnt", mispredict_cnt, 32'd0);
        chk("reset.if_pred_taken", {31'd0, if_pred_taken}, 32'd0);
        rst = 1'b0;

        // beq taken, predicted not-taken
        issue("beq_mis", 1, c_BR, 3'b000, 32'd5, 32'd5, 32'h100, 32'h140, 0, 1, 32'h140, 4'b0001, 32'd1);
        idle(32'd1);
        @(posedge clk); #1;
        chk("bht0_after_beq", {31'd0, if_pred_taken}, 32'd1);

        // Signed vs unsigned ordering and reserved func3
        issue("bge_nt", 1, c_BR, 3'b101, 32'hFFFF_FFFF, 32'd1, 32'h184, 32'h1C0, 0, 0, 32'd0, 4'b0000, 32'd1);
        issue("bgeu_t", 1, c_BR, 3'b111, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h240, 0, 1, 32'h240, 4'b0001, 32'd2);
        idle(32'd2);
        issue("f3_010", 1, c_BR, 3'b010, 32'd9, 32'd9, 32'h300, 32'h340, 1, 1, 32'h304, 4'b0000, 32'd3);
        idle(32'd3);

        // Saturation at index 3 (if_pc = 0x0C)
        if_pc = 32'h0C;
        for (int i = 0; i < 4; i++)
            issue("sat_up", 1, c_BR, 3'b000, 32'd7, 32'd7, 32'h0C, 32'h80, 1, 0, 32'd0, 4'b0001, 32'd3);
        @(posedge clk); #1;
        chk("sat_hi_pred", {31'd0, if_pred_taken}, 32'd1);
        for (int i = 0; i < 4; i++)
            issue("sat_dn", 1, c_BR, 3'b001, 32'd7, 32'd7, 32'h0C, 32'h80, 0, 0, 32'd0, 4'b0000, 32'd3);
        @(posedge clk); #1;
        chk("sat_lo_pred", {31'd0, if_pred_taken}, 32'd0);
        issue("from_00", 1, c_BR, 3'b000, 32'd7, 32'd7, 32'h0C, 32'h80, 1, 0, 32'd0, 4'b0001, 32'd3);
        @(posedge clk); #1;
        chk("sat_lo_floor", {31'd0, if_pred_taken}, 32'd0);
        issue("no_bypass", 1, c_BR, 3'b000, 32'd7, 32'd7, 32'h0C, 32'h80, 1, 0, 32'd0, 4'b0001, 32'd3);
        #1;
        chk("no_bypass_pre", {31'd0, if_pred_taken}, 32'd0);
        @(posedge clk); #1;
        chk("no_bypass_post", {31'd0, if_pred_taken}, 32'd1);

        // Shadow squash
        issue("sq_beq", 1, c_BR, 3'b000, 32'd1, 32'd1, 32'h400, 32'h440, 0, 1, 32'h440, 4'b0001, 32'd4);
        issue("sq_jal", 1, c_JAL, 3'b000, 32'd0, 32'd0, 32'h404, 32'h500, 0, 0, 32'd0, 4'b0000, 32'd4);
        idle(32'd4);

        // Jumps, auipc, PC wrap
        issue("jalr", 1, c_JR, 3'b000, 32'd0, 32'd0, 32'h600, 32'h700, 1, 1, 32'h700, 4'b0010, 32'd5);
        idle(32'd5);
        issue("jal_ok", 1, c_JAL, 3'b000, 32'd0, 32'd0, 32'h610, 32'h900, 1, 0, 32'd0, 4'b0100, 32'd5);
        issue("jal_mis", 1, c_JAL, 3'b000, 32'd0, 32'd0, 32'h614, 32'h900, 0, 1, 32'h900, 4'b0100, 32'd6);
        idle(32'd6);
        issue("auipc", 1, c_AUI, 3'b000, 32'd0, 32'd0, 32'h800, 32'h1000, 0, 0, 32'd0, 4'b1000, 32'd6);
        issue("wrap", 1, c_BR, 3'b001, 32'd3, 32'd3, 32'hFFFF_FFFC, 32'h10, 1, 1, 32'h0, 4'b0000, 32'd7);

        // Asynchronous reset between edges while a redirect is showing
        @(posedge clk); #2;
        chk("pre_areset.redirect_valid", {31'd0, redirect_valid}, 32'd1);
        rst = 1'b1;
        ex_valid = 1'b0;
        if_pc = 32'h100;
        #1;
        chk("areset.redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("areset.branch_type", {28'd0, branch_type}, 32'd0);
        chk("areset.mispredict_cnt", mispredict_cnt, 32'd0);
        chk("areset.bht0", {31'd0, if_pred_taken}, 32'd0);
        if_pc = 32'h0C;
        #1;
        chk("areset.bht3", {31'd0, if_pred_taken}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
